// File: rtl/mips_bus_arbiter_pkg.sv
// Shared definitions for the MIPS memory subsystem: core/arbiter state types and bus payload.
package mips_bus_arbiter_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = 4;
  localparam int unsigned WD_CNT_W = 16;

  // CPU core sequencer states.
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC1  = 2'd1,
    EXEC2  = 2'd2,
    HALTED = 2'd3
  } state_t;

  // Bus arbiter states.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT0 = 2'd1,
    ARB_GRANT1 = 2'd2
  } arb_state_t;

  // One Avalon-MM master command as seen downstream.
  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
  } avm_req_t;

  // Pack a requester's signals; read+write together is treated as a write.
  function automatic avm_req_t make_req(input logic [ADDR_W-1:0] address,
                                        input logic              read,
                                        input logic              write,
                                        input logic [DATA_W-1:0] writedata,
                                        input logic [BE_W-1:0]   byteenable);
    avm_req_t req;
    req.address    = address;
    req.read       = read & ~write;
    req.write      = write;
    req.writedata  = writedata;
    req.byteenable = byteenable;
    return req;
  endfunction

endpackage

// File: rtl/mips_bus_arbiter_watchdog.sv
// bus_watchdog: counts stalled cycles of a granted transfer and raises a sticky flag at TIMEOUT.
module bus_watchdog
  import mips_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic stall,
  output logic timeout_err
);

  logic [WD_CNT_W-1:0] count;
  logic [WD_CNT_W:0]   count_inc;
  logic                saturated;
  logic                hit;

  assign saturated = (count == '1);
  assign count_inc = {1'b0, count} + (WD_CNT_W + 1)'(1);
  // Flag on the very stall cycle that takes the count up to TIMEOUT; 0 disables.
  assign hit = (TIMEOUT != 0) && stall && !start && !saturated &&
               (32'(count_inc) == 32'(TIMEOUT));

  // Stall counter: cleared when a grant is about to start, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (stall && !saturated) begin
      count <= count + WD_CNT_W'(1);
    end
  end

  // Sticky error flag; only reset clears it, the transfer itself carries on.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (hit) begin
      timeout_err <= 1'b1;
    end
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: round-robin two-port Avalon-MM arbiter with grant held until transfer completion.
module mips_bus_arbiter
  import mips_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        timeout_err
);

  arb_state_t state;
  logic       last_grant;
  logic       want0;
  logic       want1;
  logic       grant_start;
  logic       grant_stall;
  avm_req_t   req0;
  avm_req_t   req1;
  avm_req_t   bus;

  assign want0 = m0_read | m0_write;
  assign want1 = m1_read | m1_write;
  assign req0  = make_req(m0_address, m0_read, m0_write, m0_writedata, m0_byteenable);
  assign req1  = make_req(m1_address, m1_read, m1_write, m1_writedata, m1_byteenable);

  // Arbitration FSM: tie goes to the port not granted last; grant held until completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (want0 && want1) begin
            state <= last_grant ? ARB_GRANT0 : ARB_GRANT1;
          end else if (want0) begin
            state <= ARB_GRANT0;
          end else if (want1) begin
            state <= ARB_GRANT1;
          end
        end
        ARB_GRANT0: begin
          if (!want0) begin
            state <= ARB_IDLE;
          end else if (!waitrequest) begin
            state      <= ARB_IDLE;
            last_grant <= 1'b0;
          end
        end
        ARB_GRANT1: begin
          if (!want1) begin
            state <= ARB_IDLE;
          end else if (!waitrequest) begin
            state      <= ARB_IDLE;
            last_grant <= 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Output steering: pass-through for the granted port, quiet bus otherwise.
  always_comb begin
    bus            = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_readdata    = '0;
    case (state)
      ARB_GRANT0: begin
        bus            = req0;
        m0_waitrequest = waitrequest;
        m0_readdata    = readdata;
      end
      ARB_GRANT1: begin
        bus            = req1;
        m1_waitrequest = waitrequest;
        m1_readdata    = readdata;
      end
      default: ;
    endcase
  end

  assign address    = bus.address;
  assign read       = bus.read;
  assign write      = bus.write;
  assign writedata  = bus.writedata;
  assign byteenable = bus.byteenable;

  // A grant begins on the edge leaving IDLE with any request pending.
  assign grant_start = (state == ARB_IDLE) && (want0 || want1);
  assign grant_stall = (state != ARB_IDLE) && waitrequest;

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .start      (grant_start),
    .stall      (grant_stall),
    .timeout_err(timeout_err)
  );

endmodule
